// File: rtl/i3c_daa_pkg.sv
// Shared constants for the I3C ENTDAA controller: top FSM states, bit-engine
// opcodes and the broadcast/CCC values used on the bus.
package i3c_daa_pkg;

  localparam logic [6:0]  BCAST_ADDR = 7'h7E;
  localparam logic [7:0]  CCC_ENTDAA = 8'h07;
  localparam int unsigned ID_BITS    = 64;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StStart    = 4'd1;
  localparam logic [3:0] StBcastW   = 4'd2;
  localparam logic [3:0] StAckW     = 4'd3;
  localparam logic [3:0] StCcc      = 4'd4;
  localparam logic [3:0] StRepStart = 4'd5;
  localparam logic [3:0] StBcastR   = 4'd6;
  localparam logic [3:0] StAckR     = 4'd7;
  localparam logic [3:0] StReadId   = 4'd8;
  localparam logic [3:0] StAddr     = 4'd9;
  localparam logic [3:0] StAckAddr  = 4'd10;
  localparam logic [3:0] StStop     = 4'd11;
  localparam logic [3:0] StDone     = 4'd12;

  localparam logic [2:0] OpStart = 3'd0;
  localparam logic [2:0] OpSr    = 3'd1;
  localparam logic [2:0] OpStop  = 3'd2;
  localparam logic [2:0] OpWrite = 3'd3;
  localparam logic [2:0] OpRead  = 3'd4;

  // Bit that makes the total number of ones (byte + bit) odd.
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/i3c_bit_engine.sv
// SCL generator and SDA driver/sampler: executes one START, Sr, STOP, bit
// write or bit read per request and reports completion with the sampled bit.
module i3c_bit_engine
  import i3c_daa_pkg::*;
#(
  parameter int unsigned SclDiv = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [2:0] op_i,
  input  logic       wbit_i,
  input  logic       sda_i,
  output logic       idle_o,
  output logic       done_o,
  output logic       rbit_o,
  output logic       scl_o,
  output logic       sda_oe_o
);

  localparam int unsigned Half   = SclDiv / 2;
  localparam logic [15:0] HalfM1 = 16'(Half - 1);
  // Requests are accepted one clock after SCL falls, so the low half is one short.
  localparam logic [15:0] HalfM2 = 16'(Half - 2);

  localparam logic [1:0] EIdle = 2'd0;
  localparam logic [1:0] ELow  = 2'd1;
  localparam logic [1:0] EHigh = 2'd2;
  localparam logic [1:0] EHold = 2'd3;

  logic [1:0]  st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic        rbit_q, rbit_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    scl_d  = scl_q;
    oe_d   = oe_q;
    rbit_d = rbit_q;
    unique case (st_q)
      EIdle: begin
        if (req_i) begin
          op_d = op_i;
          if (op_i == OpStart) begin
            oe_d  = 1'b1;
            st_d  = EHold;
            cnt_d = HalfM1;
          end else begin
            oe_d  = (op_i == OpStop) || ((op_i == OpWrite) && !wbit_i);
            st_d  = ELow;
            cnt_d = HalfM2;
          end
        end
      end
      ELow: begin
        if (cnt_q == 16'd0) begin
          scl_d  = 1'b1;
          rbit_d = sda_i;
          st_d   = EHigh;
          cnt_d  = HalfM1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      EHigh: begin
        if (cnt_q == 16'd0) begin
          if (op_q == OpSr) begin
            oe_d  = 1'b1;
            st_d  = EHold;
            cnt_d = HalfM1;
          end else if (op_q == OpStop) begin
            oe_d = 1'b0;
            st_d = EIdle;
          end else begin
            scl_d = 1'b0;
            st_d  = EIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      EHold: begin
        if (cnt_q == 16'd0) begin
          scl_d = 1'b0;
          st_d  = EIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: st_d = EIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= EIdle;
      cnt_q  <= '0;
      op_q   <= OpStart;
      scl_q  <= 1'b1;
      oe_q   <= 1'b0;
      rbit_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      scl_q  <= scl_d;
      oe_q   <= oe_d;
      rbit_q <= rbit_d;
    end
  end

  assign idle_o   = (st_q == EIdle);
  assign done_o   = (cnt_q == 16'd0) &&
                    (((st_q == EHigh) && (op_q != OpSr)) || (st_q == EHold));
  assign rbit_o   = rbit_q;
  assign scl_o    = scl_q;
  assign sda_oe_o = oe_q;

endmodule

// File: rtl/i3c_daa_controller_top.sv
// I3C SDR primary controller running ENTDAA: broadcasts 7E/W + ENTDAA, then
// reads each target's PID/BCR/DCR and hands out sequential dynamic addresses.
module i3c_daa_controller_top
  import i3c_daa_pkg::*;
#(
  parameter int unsigned SCL_DIV       = 200,
  parameter logic [6:0]  DYN_ADDR_BASE = 7'h08,
  parameter int unsigned MAX_TARGETS   = 8
) (
  input  logic i_sdr_clk,
  input  logic i_sdr_rst_n,
  input  logic i_i3c_i2c_sel,
  input  logic i_controller_en,
  output logic scl,
  inout  wire  sda,
  output logic o_sdr_rx_valid,
  output logic o_ctrl_done
);

  localparam int unsigned IdxW = (MAX_TARGETS > 1) ? $clog2(MAX_TARGETS) : 1;

  logic [3:0]         state_q, state_d;
  logic [6:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         addr_q, addr_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [MAX_TARGETS-1:0] valid_q, valid_d;
  logic [ID_BITS-1:0] id_q [MAX_TARGETS];
  logic [ID_BITS-1:0] id_d [MAX_TARGETS];
  logic               rx_valid_q, rx_valid_d;

  logic       eng_req, eng_idle, eng_done, eng_rbit, eng_wbit, sda_oe;
  logic [2:0] eng_op;
  logic [8:0] tx_word;
  logic [3:0] tx_idx;
  logic       table_full;

  // Entries fill in order, so the table is full once its last slot is valid.
  assign table_full = valid_q[MAX_TARGETS-1];

  always_comb begin
    tx_word = '0;
    case (state_q)
      StBcastW: tx_word = {BCAST_ADDR, 1'b0, 1'b0};
      StBcastR: tx_word = {BCAST_ADDR, 1'b1, 1'b0};
      StCcc:    tx_word = {CCC_ENTDAA, odd_par(CCC_ENTDAA)};
      StAddr:   tx_word = {addr_q, odd_par({1'b0, addr_q}), 1'b0};
      default:  tx_word = '0;
    endcase
  end

  assign tx_idx   = 4'd8 - bit_cnt_q[3:0];
  assign eng_wbit = tx_word[tx_idx];

  always_comb begin
    case (state_q)
      StStart:                           eng_op = OpStart;
      StRepStart:                        eng_op = OpSr;
      StStop:                            eng_op = OpStop;
      StBcastW, StCcc, StBcastR, StAddr: eng_op = OpWrite;
      default:                           eng_op = OpRead;
    endcase
  end

  assign eng_req = eng_idle && (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    id_d       = id_q;
    rx_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_controller_en) state_d = i_i3c_i2c_sel ? StStart : StDone;
      end
      StStart: begin
        if (eng_done) begin
          state_d   = StBcastW;
          bit_cnt_d = '0;
        end
      end
      StBcastW, StBcastR, StAddr: begin
        if (eng_done) begin
          if (bit_cnt_q == 7'd7) begin
            state_d = (state_q == StBcastW) ? StAckW :
                      (state_q == StBcastR) ? StAckR : StAckAddr;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      StAckW: begin
        if (eng_done) begin
          state_d   = eng_rbit ? StStop : StCcc;
          bit_cnt_d = '0;
        end
      end
      StCcc: begin
        if (eng_done) begin
          if (bit_cnt_q == 7'd8) state_d = StRepStart;
          else bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StRepStart: begin
        if (eng_done) begin
          state_d   = StBcastR;
          bit_cnt_d = '0;
        end
      end
      StAckR: begin
        if (eng_done) begin
          state_d   = (eng_rbit || table_full) ? StStop : StReadId;
          bit_cnt_d = '0;
        end
      end
      StReadId: begin
        if (eng_done) begin
          id_d[idx_q] = {id_q[idx_q][ID_BITS-2:0], eng_rbit};
          if (bit_cnt_q == 7'(ID_BITS - 1)) begin
            rx_valid_d = 1'b1;
            state_d    = StAddr;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      StAckAddr: begin
        if (eng_done) begin
          // A NACKed address leaves the slot free for the next target.
          if (!eng_rbit) begin
            valid_d[idx_q] = 1'b1;
            addr_d         = addr_q + 7'd1;
            if (idx_q != IdxW'(MAX_TARGETS - 1)) idx_d = idx_q + 1'b1;
          end
          state_d = StRepStart;
        end
      end
      StStop: begin
        if (eng_done) state_d = StDone;
      end
      StDone: begin
        if (!i_controller_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
    if (!i_sdr_rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      addr_q     <= DYN_ADDR_BASE;
      idx_q      <= '0;
      valid_q    <= '0;
      id_q       <= '{default: '0};
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  i3c_bit_engine #(
    .SclDiv(SCL_DIV)
  ) u_bit_engine (
    .clk_i   (i_sdr_clk),
    .rst_ni  (i_sdr_rst_n),
    .req_i   (eng_req),
    .op_i    (eng_op),
    .wbit_i  (eng_wbit),
    .sda_i   (sda),
    .idle_o  (eng_idle),
    .done_o  (eng_done),
    .rbit_o  (eng_rbit),
    .scl_o   (scl),
    .sda_oe_o(sda_oe)
  );

  assign sda            = sda_oe ? 1'b0 : 1'bz;
  assign o_sdr_rx_valid = rx_valid_q;
  assign o_ctrl_done    = (state_q == StDone);

endmodule

// File: tb/tb_i3c_daa_controller_top.sv
// Bench for the ENTDAA controller: scripted targets on the bus, a transaction
// model that predicts bus events, and a bus monitor that checks them.
module tb_i3c_daa_controller_top;

  localparam int unsigned SclDiv = 8;
  localparam int unsigned MaxTgt = 8;
  localparam int          Bound  = 12000;
  localparam int          EvS    = 2;
  localparam int          EvR    = 3;
  localparam int          EvP    = 4;

  logic clk = 1'b0;
  logic rst_n, sel, en, tgt_pull;
  wire  scl_w, sda_w, rxv, done;

  assign sda_w = tgt_pull ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i3c_daa_controller_top #(
    .SCL_DIV      (SclDiv),
    .DYN_ADDR_BASE(7'h08),
    .MAX_TARGETS  (MaxTgt)
  ) dut (
    .i_sdr_clk      (clk),
    .i_sdr_rst_n    (rst_n),
    .i_i3c_i2c_sel  (sel),
    .i_controller_en(en),
    .scl            (scl_w),
    .sda            (sda_w),
    .o_sdr_rx_valid (rxv),
    .o_ctrl_done    (done)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit drv_q[$];
  logic [63:0] ids[$];
  bit aacks[$];
  int exp_rx, rxv_cnt, ev_seen;
  bit mon_en = 1'b0;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Bus monitor + target responder, sampled on the inactive clock edge.
  bit p_scl = 1'b1, p_sda = 1'b1, p_rxv = 1'b0, pend = 1'b0, has_pend = 1'b0, busy = 1'b0;
  always @(negedge clk) begin : monitor
    int ev;
    ev = -1;
    if (!mon_en) begin
      has_pend = 1'b0;
      busy     = 1'b0;
    end else begin
      if (!p_scl && scl_w) begin
        pend     = sda_w;
        has_pend = 1'b1;
      end else if (p_scl && !scl_w) begin
        if (has_pend) ev = int'(pend);
        has_pend = 1'b0;
        tgt_pull = (drv_q.size() > 0) ? !drv_q.pop_front() : 1'b0;
      end else if (p_scl && scl_w && p_sda && !sda_w) begin
        ev       = busy ? EvR : EvS;
        busy     = 1'b1;
        has_pend = 1'b0;
      end else if (p_scl && scl_w && !p_sda && sda_w) begin
        ev       = EvP;
        busy     = 1'b0;
        has_pend = 1'b0;
      end
      if (ev >= 0) begin
        ev_seen++;
        if (exp_q.size() == 0) check("unexpected_bus_event", ev, -1);
        else check("bus_event", ev, exp_q.pop_front());
      end
      if (rxv) begin
        rxv_cnt++;
        check("rx_valid_one_cycle", int'(p_rxv), 0);
      end
    end
    p_scl = scl_w;
    p_sda = sda_w;
    p_rxv = rxv;
  end

  // --- transaction-level reference model ---
  task automatic push_bit(input bit b, input bit drv);
    exp_q.push_back(int'(b));
    drv_q.push_back(drv);
  endtask

  task automatic push_cond(input int ev);
    exp_q.push_back(ev);
    drv_q.push_back(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_bit(b[i], 1'b1);
  endtask

  function automatic bit odd_t(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic model_daa(input bit w_ack, input int n_tgt);
    int assigned;
    logic [7:0] a;
    bit present;
    assigned = 0;
    exp_rx   = 0;
    rxv_cnt  = 0;
    exp_q.delete();
    drv_q.delete();
    exp_q.push_back(EvS);
    push_byte(8'hFC);
    push_bit(!w_ack, !w_ack);
    if (!w_ack) begin
      push_cond(EvP);
    end else begin
      push_byte(8'h07);
      push_bit(odd_t(8'h07), 1'b1);
      for (int k = 0; k < 64; k++) begin
        push_cond(EvR);
        push_byte(8'hFD);
        present = (k < n_tgt);
        if (!present || assigned == MaxTgt) begin
          push_bit(!present, !present);
          push_cond(EvP);
          break;
        end
        push_bit(1'b0, 1'b0);
        for (int i = 63; i >= 0; i--) push_bit(ids[k][i], ids[k][i]);
        exp_rx++;
        a = 8'h08 + 8'(assigned);
        push_byte({a[6:0], odd_t({1'b0, a[6:0]})});
        push_bit(!aacks[k], !aacks[k]);
        if (aacks[k]) assigned++;
      end
    end
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    tgt_pull = 1'b0;
    en       = 1'b0;
    sel      = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_scl", int'(scl_w), 1);
    check("reset_sda", int'(sda_w), 1);
    check("reset_rx_valid", int'(rxv), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic go(input bit drop_en);
    int cyc;
    mon_en = 1'b1;
    sel    = 1'b1;
    en     = 1'b1;
    cyc    = 0;
    while (!done && cyc < Bound) begin
      @(negedge clk);
      cyc++;
      if (drop_en && cyc == 100) en = 1'b0;
    end
    check("done_reached", int'(done), 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("done_exit", int'(done), 0);
    @(negedge clk);
    check("events_left", exp_q.size(), 0);
    check("rx_valid_count", rxv_cnt, exp_rx);
    mon_en = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    rst_n    = 1'b1;
    sel      = 1'b1;
    en       = 1'b0;
    tgt_pull = 1'b0;

    // 7E/W NACK
    do_reset();
    ids.delete(); aacks.delete();
    model_daa(1'b0, 0);
    go(1'b0);

    // one target, all-zero ID
    do_reset();
    ids = '{64'h0}; aacks = '{1'b1};
    model_daa(1'b1, 1);
    go(1'b0);

    // four targets: zeros, random, ones, ones
    do_reset();
    ids = '{64'h0, {$urandom, $urandom}, '1, '1};
    aacks = '{1'b1, 1'b1, 1'b1, 1'b1};
    model_daa(1'b1, 4);
    go(1'b0);

    // random targets with random address NACKs; enable dropped mid-run
    do_reset();
    ids.delete(); aacks.delete();
    n = int'($urandom_range(2, 5));
    for (int k = 0; k < n; k++) begin
      ids.push_back({$urandom, $urandom});
      aacks.push_back(bit'($urandom_range(0, 1)));
    end
    aacks[0] = 1'b0;
    model_daa(1'b1, n);
    go(1'b1);

    // table fills, ninth target ACKs 7E/R but gets STOP
    do_reset();
    ids.delete(); aacks.delete();
    for (int k = 0; k < MaxTgt + 1; k++) begin
      ids.push_back({$urandom, $urandom});
      aacks.push_back(1'b1);
    end
    model_daa(1'b1, MaxTgt + 1);
    go(1'b0);

    // I2C mode: no bus activity, DONE quickly
    do_reset();
    exp_q.delete(); drv_q.delete();
    mon_en = 1'b1;
    sel    = 1'b0;
    en     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("i2c_done", int'(done), 1);
    repeat (20) @(negedge clk);
    check("i2c_scl_idle", int'(scl_w), 1);
    check("i2c_sda_idle", int'(sda_w), 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("i2c_done_exit", int'(done), 0);
    mon_en = 1'b0;

    // reset during READ_ID, then a fresh procedure from address 0x08
    do_reset();
    ids = '{{$urandom, $urandom}}; aacks = '{1'b1};
    model_daa(1'b1, 1);
    mon_en = 1'b1;
    sel    = 1'b1;
    en     = 1'b1;
    cyc    = 0;
    while (ev_seen < 60 && cyc < Bound) begin
      if (cyc == 0) ev_seen = 0;
      @(negedge clk);
      cyc++;
    end
    check("reached_read_id", int'(ev_seen >= 60), 1);
    #2;
    rst_n    = 1'b0;
    mon_en   = 1'b0;
    tgt_pull = 1'b0;
    en       = 1'b0;
    #1;
    check("midrst_scl", int'(scl_w), 1);
    check("midrst_sda", int'(sda_w), 1);
    check("midrst_rx_valid", int'(rxv), 0);
    check("midrst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ids = '{{$urandom, $urandom}}; aacks = '{1'b1};
    model_daa(1'b1, 1);
    go(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
